// File: rtl/processor_stage2.sv
// Decode stage: aligns fetch pointers with the registered code word, holds the word across
// stalls and squashes wrong-path words after a redirect. Optional: PROCESSOR_STAGE2_PERF_EN.
module processor_stage2 #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 no_operation_in,
  input  logic [ADDR_SIZE-1:0] ip_in,
  input  logic [ADDR_SIZE-1:0] ip_plus_one_in,
  input  logic [WORD_SIZE-1:0] code_word,
  input  logic                 stall,
  input  logic                 call_performed,
  output logic                 valid_out,
  output logic [ADDR_SIZE-1:0] ip_out,
  output logic [ADDR_SIZE-1:0] ip_plus_one_out,
  output logic [3:0]           opcode,
  output logic [2:0]           rd,
  output logic [2:0]           rs0,
  output logic [2:0]           rs1,
  output logic [WORD_SIZE-1:0] imm,
  output logic                 is_jump
`ifdef PROCESSOR_STAGE2_PERF_EN
  ,
  output logic [15:0]          perf_bubbles,
  output logic [15:0]          perf_stalls
`endif
);

  typedef enum logic {RUN = 1'b0, HELD = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_squash_cnt;
  logic [WORD_SIZE-1:0] r_hold_word;
  logic [ADDR_SIZE-1:0] r_hold_ip;
  logic [ADDR_SIZE-1:0] r_hold_ipp1;
  logic                 r_hold_nop;

  logic                 r_valid;
  logic [ADDR_SIZE-1:0] r_ip;
  logic [ADDR_SIZE-1:0] r_ipp1;
  logic [3:0]           r_opcode;
  logic [2:0]           r_rd;
  logic [2:0]           r_rs0;
  logic [2:0]           r_rs1;
  logic [WORD_SIZE-1:0] r_imm;
  logic                 r_is_jump;

  logic [WORD_SIZE-1:0] w_src_word;
  logic [ADDR_SIZE-1:0] w_src_ip;
  logic [ADDR_SIZE-1:0] w_src_ipp1;
  logic                 w_src_nop;
  logic [3:0]           w_opcode;

  // The held copy also remembers whether the captured slot was a fetch bubble.
  assign w_src_word = (r_state == HELD) ? r_hold_word : code_word;
  assign w_src_ip   = (r_state == HELD) ? r_hold_ip   : ip_in;
  assign w_src_ipp1 = (r_state == HELD) ? r_hold_ipp1 : ip_plus_one_in;
  assign w_src_nop  = (r_state == HELD) ? r_hold_nop  : no_operation_in;
  assign w_opcode   = w_src_word[WORD_SIZE-1 -: 4];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (!call_performed && stall) w_state_next = HELD;
      HELD:    if (call_performed || !stall) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_squash_cnt <= 2'd0;
      r_hold_word  <= '0;
      r_hold_ip    <= '0;
      r_hold_ipp1  <= '0;
      r_hold_nop   <= 1'b0;
      r_valid      <= 1'b0;
      r_ip         <= '0;
      r_ipp1       <= '0;
      r_opcode     <= 4'd0;
      r_rd         <= 3'd0;
      r_rs0        <= 3'd0;
      r_rs1        <= 3'd0;
      r_imm        <= '0;
      r_is_jump    <= 1'b0;
    end else if (call_performed) begin
      // Word in flight now and the one arriving next are wrong-path.
      r_valid      <= 1'b0;
      r_squash_cnt <= 2'd2;
      r_hold_word  <= '0;
      r_hold_ip    <= '0;
      r_hold_ipp1  <= '0;
      r_hold_nop   <= 1'b0;
    end else if (stall) begin
      if (r_state == RUN) begin
        r_hold_word <= code_word;
        r_hold_ip   <= ip_in;
        r_hold_ipp1 <= ip_plus_one_in;
        r_hold_nop  <= no_operation_in;
      end
    end else if (w_src_nop) begin
      r_valid <= 1'b0;
    end else begin
      r_ip      <= w_src_ip;
      r_ipp1    <= w_src_ipp1;
      r_opcode  <= w_opcode;
      r_rd      <= w_src_word[13:11];
      r_rs0     <= w_src_word[10:8];
      r_rs1     <= w_src_word[7:5];
      r_imm     <= {{(WORD_SIZE-11){w_src_word[10]}}, w_src_word[10:0]};
      r_is_jump <= (w_opcode[3:1] == 3'b111);
      if (r_squash_cnt != 2'd0) begin
        r_valid      <= 1'b0;
        r_squash_cnt <= r_squash_cnt - 2'd1;
      end else begin
        r_valid <= 1'b1;
      end
    end
  end

  assign valid_out       = r_valid;
  assign ip_out          = r_ip;
  assign ip_plus_one_out = r_ipp1;
  assign opcode          = r_opcode;
  assign rd              = r_rd;
  assign rs0             = r_rs0;
  assign rs1             = r_rs1;
  assign imm             = r_imm;
  assign is_jump         = r_is_jump;

`ifdef PROCESSOR_STAGE2_PERF_EN
  logic [15:0] r_perf_bubbles;
  logic [15:0] r_perf_stalls;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_bubbles <= 16'd0;
      r_perf_stalls  <= 16'd0;
    end else begin
      if (!r_valid && r_perf_bubbles != 16'hFFFF) r_perf_bubbles <= r_perf_bubbles + 16'd1;
      if (stall && r_perf_stalls != 16'hFFFF)     r_perf_stalls  <= r_perf_stalls + 16'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_processor_stage2.sv
// Randomized + directed bench for processor_stage2: a reference model pushes the expected
// bundle for every clock into a queue; an independent monitor pops and compares.
module tb_processor_stage2;

  logic        clock = 1'b0;
  logic        reset;
  logic        no_operation_in;
  logic [17:0] ip_in;
  logic [17:0] ip_plus_one_in;
  logic [17:0] code_word;
  logic        stall;
  logic        call_performed;
  logic        valid_out;
  logic [17:0] ip_out;
  logic [17:0] ip_plus_one_out;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs0, rs1;
  logic [17:0] imm;
  logic        is_jump;

  processor_stage2 #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
    .clock(clock), .reset(reset), .no_operation_in(no_operation_in),
    .ip_in(ip_in), .ip_plus_one_in(ip_plus_one_in), .code_word(code_word),
    .stall(stall), .call_performed(call_performed), .valid_out(valid_out),
    .ip_out(ip_out), .ip_plus_one_out(ip_plus_one_out), .opcode(opcode),
    .rd(rd), .rs0(rs0), .rs1(rs1), .imm(imm), .is_jump(is_jump)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          v;
    logic [17:0] ip;
    logic [17:0] ipp1;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs0;
    logic [2:0]  rs1;
    logic [17:0] imm;
    bit          j;
  } bundle_t;

  bundle_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  // Reference model: the last bundle shown, a pending (stalled) fetch slot and a
  // count of upcoming words that belong to the abandoned path.
  bundle_t     m_out;
  bit          m_pending;
  logic [17:0] m_p_word, m_p_ip, m_p_ipp1;
  bit          m_p_nop;
  int          m_kill;

  function automatic bundle_t decode(input int unsigned w, input logic [17:0] ip, input logic [17:0] ipp1);
    bundle_t     e;
    int unsigned low;
    low    = w % 2048;
    e.v    = 1'b1;
    e.ip   = ip;
    e.ipp1 = ipp1;
    e.op   = 4'(w / 16384);
    e.rd   = 3'((w / 2048) % 8);
    e.rs0  = 3'((w / 256) % 8);
    e.rs1  = 3'((w / 32) % 8);
    e.imm  = (low >= 1024) ? 18'(low + 32'h3F800) : 18'(low);
    e.j    = (e.op >= 4'd14);
    return e;
  endfunction

  task automatic model_clear();
    m_out     = '{default: '0};
    m_pending = 1'b0;
    m_p_word  = '0; m_p_ip = '0; m_p_ipp1 = '0; m_p_nop = 1'b0;
    m_kill    = 0;
  endtask

  task automatic model_step();
    logic [17:0] w, a, b;
    bit          nop;
    if (call_performed) begin
      m_out.v   = 1'b0;
      m_kill    = 2;
      m_pending = 1'b0;
    end else if (stall) begin
      if (!m_pending) begin
        m_pending = 1'b1;
        m_p_word = code_word; m_p_ip = ip_in; m_p_ipp1 = ip_plus_one_in; m_p_nop = no_operation_in;
      end
    end else begin
      if (m_pending) begin w = m_p_word; a = m_p_ip; b = m_p_ipp1; nop = m_p_nop; end
      else begin w = code_word; a = ip_in; b = ip_plus_one_in; nop = no_operation_in; end
      m_pending = 1'b0;
      if (nop) m_out.v = 1'b0;
      else begin
        m_out = decode(w, a, b);
        if (m_kill > 0) begin
          m_out.v = 1'b0;
          m_kill--;
        end
      end
    end
    exp_q.push_back(m_out);
  endtask

  task automatic drive(input bit st, input bit nop, input bit call, input logic [17:0] ip, input logic [17:0] w);
    @(negedge clock);
    reset           = 1'b1;
    stall           = st;
    no_operation_in = nop;
    call_performed  = call;
    ip_in           = ip;
    ip_plus_one_in  = ip + 18'd1;
    code_word       = w;
    model_step();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_valid", 32'(valid_out), 32'd0);
    check("async_reset_opcode", 32'(opcode), 32'd0);
    check("async_reset_ip", 32'(ip_out), 32'd0);
    @(negedge clock);
    exp_q.delete();
    model_clear();
  endtask

  // Monitor: one expected bundle per clock while out of reset.
  always @(posedge clock) begin
    bundle_t e;
    bit      bad;
    #1;
    if (reset && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      bad = (valid_out !== e.v);
      if (e.v)
        bad = bad || (ip_out !== e.ip) || (ip_plus_one_out !== e.ipp1) || (opcode !== e.op) ||
              (rd !== e.rd) || (rs0 !== e.rs0) || (rs1 !== e.rs1) || (imm !== e.imm) || (is_jump !== e.j);
      n_checks++;
      if (bad) begin
        n_errors++;
        $display("FAIL bundle got v=%0b ip=%h ipp1=%h op=%h rd=%0d rs0=%0d rs1=%0d imm=%h j=%0b want v=%0b ip=%h ipp1=%h op=%h rd=%0d rs0=%0d rs1=%0d imm=%h j=%0b",
                 valid_out, ip_out, ip_plus_one_out, opcode, rd, rs0, rs1, imm, is_jump,
                 e.v, e.ip, e.ipp1, e.op, e.rd, e.rs0, e.rs1, e.imm, e.j);
      end else begin
        $display("txn v=%0b ip=%h op=%h imm=%h", valid_out, ip_out, opcode, imm);
      end
    end
  end

  initial begin
    logic [17:0] fip;
    bit          st, nop, call;
    reset = 1'b0; stall = 1'b0; no_operation_in = 1'b1; call_performed = 1'b0;
    ip_in = '0; ip_plus_one_in = '0; code_word = '0;
    model_clear();
    repeat (2) @(negedge clock);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_opcode", 32'(opcode), 32'd0);
    check("reset_imm", 32'(imm), 32'd0);

    // Straight-line stream
    drive(0, 0, 0, 18'd0, 18'h0A123);
    drive(0, 0, 0, 18'd1, 18'h1C045);
    @(posedge clock); #2;
    check("stream_opcode", 32'(opcode), 32'd7);
    check("stream_ip", 32'(ip_out), 32'd1);

    // Stall for three cycles while the live word changes
    drive(0, 0, 0, 18'd2, 18'h2A5A5);
    drive(1, 0, 0, 18'd3, 18'h33333);
    drive(1, 0, 0, 18'd4, 18'h04444);
    drive(1, 0, 0, 18'd4, 18'h05555);
    drive(0, 0, 0, 18'd4, 18'h3FFFF);
    drive(0, 0, 0, 18'd4, 18'h06666);

    // Redirect at ip 5: two wrong-path words then the target
    drive(0, 0, 1, 18'd5, 18'h3C010);
    drive(0, 0, 0, 18'd6, 18'h11111);
    drive(0, 0, 0, 18'd7, 18'h22222);
    drive(0, 0, 0, 18'h00100, 18'h12345);
    drive(0, 0, 0, 18'h00101, 18'h23456);

    // Redirect and stall together, then a stall during squash
    drive(0, 0, 0, 18'd8, 18'h07777);
    drive(1, 0, 1, 18'd9, 18'h08888);
    drive(1, 0, 0, 18'd10, 18'h09999);
    drive(0, 0, 0, 18'd10, 18'h0AAAA);
    drive(0, 0, 0, 18'd11, 18'h0BBBB);
    drive(0, 0, 0, 18'd12, 18'h0CCCC);

    // Immediate sign extension and pointer wrap
    drive(0, 0, 0, 18'h3FFFF, 18'h207FF);
    @(posedge clock); #2;
    check("imm_neg", 32'(imm), 32'h3FFFF);
    check("ipp1_wrap", 32'(ip_plus_one_out), 32'd0);
    drive(0, 0, 0, 18'd13, 18'h203FF);
    @(posedge clock); #2;
    check("imm_pos", 32'(imm), 32'h003FF);

    // Bubble, then bubble captured by a stall
    drive(0, 1, 0, 18'd14, 18'h3E000);
    drive(0, 0, 0, 18'd14, 18'h3E001);
    drive(1, 1, 0, 18'd15, 18'h3F002);
    drive(0, 0, 0, 18'd15, 18'h3F003);
    drive(0, 0, 0, 18'd16, 18'h3F004);

    // Reset in the middle of a stall
    drive(1, 0, 0, 18'd17, 18'h15555);
    do_reset();

    // Randomized fetch traffic with occasional mid-stream resets
    fip = 18'd0;
    for (int i = 0; i < 3000; i++) begin
      st   = ($urandom_range(0, 99) < 20);
      nop  = ($urandom_range(0, 99) < 15);
      call = ($urandom_range(0, 99) < 7);
      drive(st, nop, call, fip, 18'($urandom));
      if (call) fip = ($urandom_range(0, 3) == 0) ? 18'h3FFFE : 18'($urandom);
      else if (!st && !nop) fip = fip + 18'd1;
      if (i % 1000 == 999) do_reset();
    end

    @(negedge clock);
    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
